// File: rtl/fir_serial_tx.sv
// fir_serial_tx: transmit end of the framed serial link feeding the DAC/codec.
// Signed samples are queued in a small FIFO and shifted out MSB-first as
// FRAME_BITS-bit frames (sclk / fs / sdata), SCLK_DIV clk cycles per bit.
// Optional feature macro FIR_TX_PARITY_EN: when defined, the first pad bit
// after the sample carries the XOR of all sample bits.
module fir_serial_tx #(
  parameter int WIDTH_data = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int SCLK_DIV   = 4,
  parameter int FRAME_BITS = 32
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic signed [WIDTH_data-1:0]       data_in,
  input  logic                               in_valid,
  input  logic                               clr_ovf,
  output logic                               sclk,
  output logic                               fs,
  output logic                               sdata,
  output logic                               busy,
  output logic                               overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMR_W = $clog2(SCLK_DIV);
  localparam int BIT_W = $clog2(FRAME_BITS);

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCLK_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(SCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

`ifdef FIR_TX_PARITY_EN
  // Even parity: XOR of every sample bit.
  function automatic logic even_parity(input logic signed [WIDTH_data-1:0] s);
    return ^s;
  endfunction
`endif

  // Frame image: sample left-justified, pad bits zero (parity in first pad bit if enabled).
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic signed [WIDTH_data-1:0] s);
    logic [FRAME_BITS-1:0] f;
    f = '0;
    f[FRAME_BITS-1 -: WIDTH_data] = s;
`ifdef FIR_TX_PARITY_EN
    f[FRAME_BITS-1-WIDTH_data] = even_parity(s);
`endif
    return f;
  endfunction

  state_t                        state_q, state_d;
  logic signed [WIDTH_data-1:0]  mem_q [FIFO_DEPTH];
  logic signed [WIDTH_data-1:0]  head;
  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]              level_q, level_d;
  logic                          ovf_q, ovf_d;
  logic [TMR_W-1:0]              timer_q, timer_d;
  logic [BIT_W-1:0]              bit_q, bit_d;
  logic [FRAME_BITS-1:0]         shift_q, shift_d;
  logic                          empty, full, frame_end, pop, push, drop;

  // FIFO handshake: pop when idle or at the last clk of a frame; a push into a
  // full FIFO is still accepted if the same edge pops.
  always_comb begin
    empty     = (level_q == '0);
    full      = (level_q == LVL_FULL);
    frame_end = (state_q == SHIFT) && (timer_q == TMR_LAST) && (bit_q == BIT_LAST);
    pop       = !empty && ((state_q == IDLE) || frame_end);
    push      = in_valid && (!full || pop);
    drop      = in_valid && full && !pop;
    head      = mem_q[rd_ptr_q];
  end

  // FIFO pointers, fill level and sticky overflow (a drop beats a clear).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  // Next state: load a frame on pop, step the bit timer, shift on timer wrap.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (state_q == IDLE) begin
      if (pop) begin
        state_d = SHIFT;
        timer_d = '0;
        bit_d   = '0;
        shift_d = build_frame(head);
      end
    end else begin
      if (frame_end) begin
        timer_d = '0;
        bit_d   = '0;
        if (pop) shift_d = build_frame(head);
        else     state_d = IDLE;
      end else if (timer_q == TMR_LAST) begin
        timer_d = '0;
        bit_d   = bit_q + BIT_W'(1);
        shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end
  end

  // Control state, cleared asynchronously so a partial frame is abandoned at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      timer_q  <= '0;
      bit_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
    end
  end

  // Sample storage and shift register; outputs are gated by state, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
    shift_q <= shift_d;
  end

  assign busy       = (state_q == SHIFT);
  assign sclk       = busy && (timer_q >= TMR_HALF);
  assign fs         = busy && (bit_q == '0);
  assign sdata      = busy && shift_q[FRAME_BITS-1];
  assign overflow   = ovf_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_fir_serial_tx.sv
// Directed bench for fir_serial_tx at default parameters (24/4/4/32).
module tb_fir_serial_tx;

  logic               clk;
  logic               reset_n;
  logic signed [23:0] data_in;
  logic               in_valid;
  logic               clr_ovf;
  logic               sclk, fs, sdata, busy, overflow;
  logic [2:0]         fifo_level;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  fir_serial_tx #(
    .WIDTH_data(24),
    .FIFO_DEPTH(4),
    .SCLK_DIV  (4),
    .FRAME_BITS(32)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .clr_ovf   (clr_ovf),
    .sclk      (sclk),
    .fs        (fs),
    .sdata     (sdata),
    .busy      (busy),
    .overflow  (overflow),
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at 2000000 ns");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for fs, then records one 128-clk frame; returns observations only.
  task automatic capture_frame(input int max_wait, output logic [31:0] word, output bit found,
                               output int waited, output int start_cyc, output bit shape_ok);
    int b;
    int t;
    word      = '0;
    found     = 1'b0;
    waited    = 0;
    start_cyc = 0;
    shape_ok  = 1'b1;
    for (int k = 0; k <= max_wait; k++) begin
      if (fs === 1'b1) begin
        found = 1'b1;
        break;
      end
      waited++;
      tick();
    end
    if (found) begin
      start_cyc = cyc;
      for (int i = 0; i < 128; i++) begin
        b = i / 4;
        t = i % 4;
        if (sclk !== (t >= 2)) shape_ok = 1'b0;
        if (fs !== (b == 0)) shape_ok = 1'b0;
        if (busy !== 1'b1) shape_ok = 1'b0;
        if (t == 0) word[31-b] = sdata;
        else if (sdata !== word[31-b]) shape_ok = 1'b0;
        tick();
      end
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    clr_ovf  = 1'b0;
    data_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sclk, fs, sdata, busy, overflow} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 00000", {sclk, fs, sdata, busy, overflow});
    end
    checks++;
    if (fifo_level !== 3'd0) begin
      failures++;
      $display("FAIL reset_level: got %0d expected 0", fifo_level);
    end
    reset_n = 1'b1;
    repeat (5) tick();
    checks++;
    if ({sclk, fs, sdata, busy, overflow, fifo_level} !== 8'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got %b expected 00000000",
               {sclk, fs, sdata, busy, overflow, fifo_level});
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] w;
    bit f, ok;
    int wt, st;
    data_in  = 24'hA50F3C;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({fs, busy, fifo_level} !== {1'b0, 1'b0, 3'd1}) begin
      failures++;
      $display("FAIL single_after_push: got fs=%b busy=%b level=%0d expected fs=0 busy=0 level=1",
               fs, busy, fifo_level);
    end
    capture_frame(3, w, f, wt, st, ok);
    checks++;
    if (!(f && wt == 1)) begin
      failures++;
      $display("FAIL single_latency: got found=%0d wait=%0d expected found=1 wait=1", f, wt);
    end
    checks++;
    if (w !== 32'hA50F3C00) begin
      failures++;
      $display("FAIL single_word: got %h expected a50f3c00", w);
    end
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL single_shape: got %0d expected 1", ok);
    end
    checks++;
    if ({busy, fs, sclk, sdata, fifo_level} !== 7'b0) begin
      failures++;
      $display("FAIL single_idle_end: got busy=%b level=%0d expected busy=0 level=0", busy, fifo_level);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3];
    bit f [3];
    bit ok [3];
    int wt [3];
    int st [3];
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h00000300;
    exp_w[1] = 32'hFFFFFF00;
    exp_w[2] = 32'hC0000000;
    fork
      begin
        data_in  = 24'h000003;
        in_valid = 1'b1;
        tick();
        data_in = 24'hFFFFFF;
        tick();
        data_in = 24'hC00000;
        tick();
        in_valid = 1'b0;
      end
      begin
        for (int n = 0; n < 3; n++) capture_frame(4, w[n], f[n], wt[n], st[n], ok[n]);
      end
    join
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (!(f[n] && ok[n]) || w[n] !== exp_w[n]) begin
        failures++;
        $display("FAIL b2b_frame%0d: got found=%0d shape=%0d word=%h expected 1 1 %h",
                 n, f[n], ok[n], w[n], exp_w[n]);
      end
    end
    checks++;
    if (wt[0] != 2 || wt[1] != 0 || wt[2] != 0) begin
      failures++;
      $display("FAIL b2b_gaps: got waits %0d/%0d/%0d expected 2/0/0", wt[0], wt[1], wt[2]);
    end
    checks++;
    if (st[1] - st[0] != 128 || st[2] - st[1] != 128) begin
      failures++;
      $display("FAIL b2b_fs_period: got %0d/%0d expected 128/128", st[1] - st[0], st[2] - st[1]);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle_end: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_overflow();
    logic signed [23:0] s [6];
    logic [31:0] exp_w [5];
    logic [31:0] w [5];
    bit f [5];
    bit ok [5];
    int wt [5];
    int st [5];
    logic [2:0] peak;
    logic ovf_before, ovf_after;
    s[0] = 24'h000003; s[1] = 24'h00000F; s[2] = 24'hFFFFFF;
    s[3] = 24'h800001; s[4] = 24'hC00000; s[5] = 24'h111111;
    exp_w[0] = 32'h00000300; exp_w[1] = 32'h00000F00; exp_w[2] = 32'hFFFFFF00;
    exp_w[3] = 32'h80000100; exp_w[4] = 32'hC0000000;
    peak = '0;
    ovf_before = 1'b0;
    ovf_after  = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          data_in  = s[i];
          in_valid = 1'b1;
          clr_ovf  = (i == 5);
          tick();
          if (fifo_level > peak) peak = fifo_level;
          if (i == 4) ovf_before = overflow;
        end
        in_valid  = 1'b0;
        clr_ovf   = 1'b0;
        ovf_after = overflow;
      end
      begin
        for (int n = 0; n < 5; n++) capture_frame(4, w[n], f[n], wt[n], st[n], ok[n]);
      end
    join
    checks++;
    if (peak !== 3'd4) begin
      failures++;
      $display("FAIL ovf_peak_level: got %0d expected 4", peak);
    end
    checks++;
    if (ovf_before !== 1'b0) begin
      failures++;
      $display("FAIL ovf_before_drop: got %b expected 0", ovf_before);
    end
    checks++;
    if (ovf_after !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set_beats_clr: got %b expected 1", ovf_after);
    end
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (!(f[n] && ok[n]) || w[n] !== exp_w[n] || (n > 0 && wt[n] != 0)) begin
        failures++;
        $display("FAIL ovf_frame%0d: got found=%0d shape=%0d word=%h wait=%0d expected 1 1 %h",
                 n, f[n], ok[n], w[n], wt[n], exp_w[n]);
      end
    end
    checks++;
    if ({busy, fifo_level, overflow} !== {1'b0, 3'd0, 1'b1}) begin
      failures++;
      $display("FAIL ovf_after_frames: got busy=%b level=%0d ovf=%b expected 0 0 1",
               busy, fifo_level, overflow);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: got %b expected 0", overflow);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] w;
    bit f, ok;
    int wt, st;
    data_in  = 24'hFFFFFF;
    in_valid = 1'b1;
    tick();
    data_in = 24'h123456;
    tick();
    data_in = 24'h654321;
    tick();
    in_valid = 1'b0;
    // Frame started one edge ago; 41 more edges land in bit 10, timer 2.
    repeat (41) tick();
    checks++;
    if ({busy, fs, sclk, sdata, fifo_level} !== {4'b1011, 3'd2}) begin
      failures++;
      $display("FAIL midframe_pre: got busy=%b fs=%b sclk=%b sdata=%b level=%0d expected 1 0 1 1 2",
               busy, fs, sclk, sdata, fifo_level);
    end
    reset_n = 1'b0;
    #2;
    checks++;
    if ({sclk, fs, sdata, busy, overflow, fifo_level} !== 8'b0) begin
      failures++;
      $display("FAIL midframe_async_reset: got %b expected 00000000",
               {sclk, fs, sdata, busy, overflow, fifo_level});
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy, fs, fifo_level} !== 5'b0) begin
      failures++;
      $display("FAIL midframe_no_resume: got busy=%b fs=%b level=%0d expected 0 0 0", busy, fs, fifo_level);
    end
    data_in  = 24'h0A0A0A;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    capture_frame(3, w, f, wt, st, ok);
    checks++;
    if (!(f && ok && wt == 1) || w !== 32'h0A0A0A00) begin
      failures++;
      $display("FAIL midframe_fresh_frame: got found=%0d shape=%0d wait=%0d word=%h expected 1 1 1 0a0a0a00",
               f, ok, wt, w);
    end
  endtask

  task automatic test_parity();
    logic [31:0] w;
    bit f, ok;
    int wt, st;
    logic [31:0] exp1;
`ifdef FIR_TX_PARITY_EN
    exp1 = 32'h00000180;
`else
    exp1 = 32'h00000100;
`endif
    data_in  = 24'h000001;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    capture_frame(3, w, f, wt, st, ok);
    checks++;
    if (!(f && ok) || w !== exp1) begin
      failures++;
      $display("FAIL parity_odd_sample: got found=%0d shape=%0d word=%h expected 1 1 %h", f, ok, w, exp1);
    end
    data_in  = 24'h000003;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    capture_frame(3, w, f, wt, st, ok);
    checks++;
    if (!(f && ok) || w !== 32'h00000300) begin
      failures++;
      $display("FAIL parity_even_sample: got found=%0d shape=%0d word=%h expected 1 1 00000300", f, ok, w);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
